// File: rtl/dma_rx_tag_order_pkg.sv
// Shared constants and types for the DMA RX tag-order stage.
package dma_rx_pkg;

    localparam int NUM_TAGS = 32;
    localparam int TAG_W    = 5;
    localparam int LEN_W    = 11;
    localparam int ENTRY_W  = TAG_W + LEN_W + 1;

    // One order-queue entry, kept in issue order.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [LEN_W-1:0] len;
        logic             last;
    } order_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2,
        FREE      = 2'd3
    } rx_state_e;

endpackage

// File: rtl/dma_rx_tag_order_if.sv
// Handshake bundle between requester, completion writer, data process
// stage, tag allocator and the tag-order block.
interface dma_rx_tag_order_if;
    import dma_rx_pkg::*;

    logic             alloc_valid;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic [LEN_W-1:0] alloc_len;
    logic             alloc_last;
    logic             cpl_done_valid;
    logic [TAG_W-1:0] cpl_done_tag;
    logic             tag_rx_req;
    logic             tag_rx_ack;
    logic             tag_rx_last;
    logic [TAG_W-1:0] tag_rx_number;
    logic [LEN_W-1:0] tag_rx_length;
    logic             tag_rx_done;
    logic             tag_free_valid;
    logic [TAG_W-1:0] tag_free_tag;
    logic [TAG_W:0]   outstanding;
    logic             err_unexp_cpl;
    logic             cpl_timeout;

    // Surrounding logic (requester, completion writer, data process, allocator)
    modport master (
        output alloc_valid, alloc_tag, alloc_len, alloc_last,
        output cpl_done_valid, cpl_done_tag,
        output tag_rx_ack, tag_rx_done,
        input  alloc_ready, tag_rx_req, tag_rx_last, tag_rx_number, tag_rx_length,
        input  tag_free_valid, tag_free_tag, outstanding, err_unexp_cpl, cpl_timeout
    );

    // Tag-order block
    modport slave (
        input  alloc_valid, alloc_tag, alloc_len, alloc_last,
        input  cpl_done_valid, cpl_done_tag,
        input  tag_rx_ack, tag_rx_done,
        output alloc_ready, tag_rx_req, tag_rx_last, tag_rx_number, tag_rx_length,
        output tag_free_valid, tag_free_tag, outstanding, err_unexp_cpl, cpl_timeout
    );

endinterface

// File: rtl/dma_rx_tag_order_fifo.sv
// Show-ahead synchronous FIFO holding order entries; storage has no reset
// so it maps onto distributed RAM.
module dma_tag_fifo
    import dma_rx_pkg::*;
#(
    parameter int DEPTH = NUM_TAGS,
    parameter int WIDTH = ENTRY_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage write, no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Pointers and count; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dma_rx_tag_order.sv
// Presents completed read tags to the RX data process stage strictly in
// issue order, then returns each tag to the allocator once drained.
module dma_rx_tag_order
    import dma_rx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535,
    localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                clk,
    input  logic                rst,
    dma_rx_tag_order_if.slave   bus
);

    order_entry_t        head, push_entry;
    logic [ENTRY_W-1:0]  head_raw;
    logic                full, empty, push, pop;
    logic [TAG_W:0]      count;

    logic [NUM_TAGS-1:0] pend_q, pend_d, done_q, done_d;
    logic                cpl_ok, err_q;

    rx_state_e           state_q, state_d;
    logic                req_q, req_d, last_q, last_d;
    logic [TAG_W-1:0]    num_q, num_d;
    logic [LEN_W-1:0]    len_q, len_d;

    logic [CNT_W-1:0]    tmo_cnt_q;
    logic                tmo_run, tmo_pulse_q;

    assign push       = bus.alloc_valid && !full;
    assign pop        = (state_q == FREE);
    assign push_entry = '{tag: bus.alloc_tag, len: bus.alloc_len, last: bus.alloc_last};
    assign head       = order_entry_t'(head_raw);

    dma_tag_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .head_o      (head_raw)
    );

    // A completion is only legal for an outstanding tag not yet marked done;
    // a completion for the head during its FREE cycle fails this test too.
    assign cpl_ok = bus.cpl_done_valid && pend_q[bus.cpl_done_tag] && !done_q[bus.cpl_done_tag];

    // Bitmap next state: completion set, then free clears, then allocation sets
    always_comb begin
        pend_d = pend_q;
        done_d = done_q;
        if (cpl_ok) done_d[bus.cpl_done_tag] = 1'b1;
        if (pop) begin
            pend_d[head.tag] = 1'b0;
            done_d[head.tag] = 1'b0;
        end
        if (push) pend_d[bus.alloc_tag] = 1'b1;
    end

    // Bitmaps and sticky unexpected-completion flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            done_q <= done_d;
            if (bus.cpl_done_valid && !cpl_ok) err_q <= 1'b1;
        end
    end

    // Drain sequencing; request fields are captured on entry to REQ and
    // held until the next request so they stay valid through WAIT_DONE
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        num_d   = num_q;
        len_d   = len_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (!empty && done_q[head.tag]) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    num_d   = head.tag;
                    len_d   = head.len;
                    last_d  = head.last;
                end
            end
            REQ: begin
                if (bus.tag_rx_ack) begin
                    state_d = WAIT_DONE;
                    req_d   = 1'b0;
                end
            end
            WAIT_DONE: begin
                if (bus.tag_rx_done) state_d = FREE;
            end
            FREE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            num_q   <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            num_q   <= num_d;
            len_q   <= len_d;
            last_q  <= last_d;
        end
    end

    // The head only changes on a pop, which happens outside IDLE, so
    // dropping out of the run condition also covers the head-change reset.
    assign tmo_run = (state_q == IDLE) && !empty && !done_q[head.tag];

    // Head wait counter; pulses once on reaching the limit, then saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_pulse_q <= tmo_run && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
            if (!tmo_run)
                tmo_cnt_q <= '0;
            else if (tmo_cnt_q != CNT_W'(TIMEOUT_CYC))
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign bus.alloc_ready    = !full;
    assign bus.outstanding    = count;
    assign bus.tag_rx_req     = req_q;
    assign bus.tag_rx_number  = num_q;
    assign bus.tag_rx_length  = len_q;
    assign bus.tag_rx_last    = last_q;
    assign bus.tag_free_valid = pop;
    assign bus.tag_free_tag   = pop ? head.tag : '0;
    assign bus.err_unexp_cpl  = err_q;
    assign bus.cpl_timeout    = tmo_pulse_q;

endmodule

// File: tb/tb_dma_rx_tag_order.sv
// Directed self-checking bench for dma_rx_tag_order.
module tb_dma_rx_tag_order;
    import dma_rx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   free_cnt = 0;

    dma_rx_tag_order_if bus_if();

    dma_rx_tag_order #(.TIMEOUT_CYC(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #4 clk = ~clk;

    // Count every cycle that carries a free pulse
    always @(negedge clk) begin
        if (bus_if.tag_free_valid) free_cnt <= free_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.alloc_valid    = 1'b0;
        bus_if.alloc_tag      = '0;
        bus_if.alloc_len      = '0;
        bus_if.alloc_last     = 1'b0;
        bus_if.cpl_done_valid = 1'b0;
        bus_if.cpl_done_tag   = '0;
        bus_if.tag_rx_ack     = 1'b0;
        bus_if.tag_rx_done    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic alloc(input logic [TAG_W-1:0] t, input logic [LEN_W-1:0] l, input logic lst);
        bus_if.alloc_valid = 1'b1;
        bus_if.alloc_tag   = t;
        bus_if.alloc_len   = l;
        bus_if.alloc_last  = lst;
        tick();
        bus_if.alloc_valid = 1'b0;
    endtask

    task automatic cpl(input logic [TAG_W-1:0] t);
        bus_if.cpl_done_valid = 1'b1;
        bus_if.cpl_done_tag   = t;
        tick();
        bus_if.cpl_done_valid = 1'b0;
    endtask

    // Waits (bounded) for a request, acks it, signals done, waits (bounded)
    // for the free pulse. Returns in the FREE cycle.
    task automatic drain(output logic got_req, output logic [TAG_W-1:0] n,
                         output logic [LEN_W-1:0] l, output logic lst,
                         output logic got_free, output logic [TAG_W-1:0] ft);
        got_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.tag_rx_req) begin
                got_req = 1'b1;
                break;
            end
            tick();
        end
        n   = bus_if.tag_rx_number;
        l   = bus_if.tag_rx_length;
        lst = bus_if.tag_rx_last;
        bus_if.tag_rx_ack = 1'b1;
        tick();
        bus_if.tag_rx_ack = 1'b0;
        bus_if.tag_rx_done = 1'b1;
        tick();
        bus_if.tag_rx_done = 1'b0;
        got_free = 1'b0;
        ft = '0;
        for (int i = 0; i < 5; i++) begin
            if (bus_if.tag_free_valid) begin
                got_free = 1'b1;
                ft = bus_if.tag_free_tag;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        checks++; if (bus_if.alloc_ready !== 1'b1) $display("FAIL reset alloc_ready got %b want 1", bus_if.alloc_ready); else passed++;
        checks++; if (bus_if.tag_rx_req !== 1'b0) $display("FAIL reset tag_rx_req got %b want 0", bus_if.tag_rx_req); else passed++;
        checks++; if (bus_if.outstanding !== 6'd0) $display("FAIL reset outstanding got %0d want 0", bus_if.outstanding); else passed++;
        checks++; if (bus_if.err_unexp_cpl !== 1'b0) $display("FAIL reset err got %b want 0", bus_if.err_unexp_cpl); else passed++;
        checks++; if (bus_if.tag_free_valid !== 1'b0) $display("FAIL reset free_valid got %b want 0", bus_if.tag_free_valid); else passed++;
        checks++; if (bus_if.cpl_timeout !== 1'b0) $display("FAIL reset timeout got %b want 0", bus_if.cpl_timeout); else passed++;
    endtask

    task automatic test_single();
        logic gr, gf, lst;
        logic [TAG_W-1:0] n, ft;
        logic [LEN_W-1:0] l;
        do_reset();
        alloc(5'd3, 11'd64, 1'b1);
        checks++; if (bus_if.outstanding !== 6'd1) $display("FAIL single outstanding got %0d want 1", bus_if.outstanding); else passed++;
        checks++; if (bus_if.tag_rx_req !== 1'b0) $display("FAIL single early_req got %b want 0", bus_if.tag_rx_req); else passed++;
        cpl(5'd3);
        drain(gr, n, l, lst, gf, ft);
        checks++; if (gr !== 1'b1) $display("FAIL single req_seen got %b want 1", gr); else passed++;
        checks++; if (n !== 5'd3) $display("FAIL single number got %0d want 3", n); else passed++;
        checks++; if (l !== 11'd64) $display("FAIL single length got %0d want 64", l); else passed++;
        checks++; if (lst !== 1'b1) $display("FAIL single last got %b want 1", lst); else passed++;
        checks++; if (gf !== 1'b1) $display("FAIL single free_seen got %b want 1", gf); else passed++;
        checks++; if (ft !== 5'd3) $display("FAIL single free_tag got %0d want 3", ft); else passed++;
        tick();
        checks++; if (bus_if.outstanding !== 6'd0) $display("FAIL single outstanding_end got %0d want 0", bus_if.outstanding); else passed++;
        checks++; if (bus_if.err_unexp_cpl !== 1'b0) $display("FAIL single err got %b want 0", bus_if.err_unexp_cpl); else passed++;
    endtask

    task automatic test_reversed();
        logic gr, gf, lst;
        logic [TAG_W-1:0] n, ft;
        logic [LEN_W-1:0] l;
        logic seen_req;
        do_reset();
        alloc(5'd0, 11'd32, 1'b0);
        alloc(5'd1, 11'd32, 1'b0);
        alloc(5'd2, 11'd32, 1'b1);
        seen_req = 1'b0;
        cpl(5'd2);
        for (int i = 0; i < 3; i++) begin seen_req |= bus_if.tag_rx_req; tick(); end
        cpl(5'd1);
        for (int i = 0; i < 3; i++) begin seen_req |= bus_if.tag_rx_req; tick(); end
        checks++; if (seen_req !== 1'b0) $display("FAIL reversed early_req got %b want 0", seen_req); else passed++;
        cpl(5'd0);
        for (int k = 0; k < 3; k++) begin
            drain(gr, n, l, lst, gf, ft);
            checks++; if (gr !== 1'b1 || n !== 5'(k)) $display("FAIL reversed req_order got req=%b num=%0d want num=%0d", gr, n, k); else passed++;
            checks++; if (l !== 11'd32 || lst !== (k == 2)) $display("FAIL reversed fields got len=%0d last=%b want len=32 last=%b", l, lst, (k == 2)); else passed++;
            checks++; if (gf !== 1'b1 || ft !== 5'(k)) $display("FAIL reversed free_order got free=%b tag=%0d want tag=%0d", gf, ft, k); else passed++;
        end
        tick();
        checks++; if (bus_if.outstanding !== 6'd0) $display("FAIL reversed outstanding got %0d want 0", bus_if.outstanding); else passed++;
    endtask

    task automatic test_full();
        logic gr, gf, lst;
        logic [TAG_W-1:0] n, ft;
        logic [LEN_W-1:0] l;
        do_reset();
        for (int i = 0; i < 32; i++) alloc(5'(i), 11'(i + 1), 1'b0);
        checks++; if (bus_if.alloc_ready !== 1'b0) $display("FAIL full alloc_ready got %b want 0", bus_if.alloc_ready); else passed++;
        checks++; if (bus_if.outstanding !== 6'd32) $display("FAIL full outstanding got %0d want 32", bus_if.outstanding); else passed++;
        alloc(5'd0, 11'd9, 1'b0);
        checks++; if (bus_if.outstanding !== 6'd32) $display("FAIL full push_ignored got %0d want 32", bus_if.outstanding); else passed++;
        cpl(5'd0);
        drain(gr, n, l, lst, gf, ft);
        checks++; if (gr !== 1'b1 || n !== 5'd0 || l !== 11'd1) $display("FAIL full head got req=%b num=%0d len=%0d want num=0 len=1", gr, n, l); else passed++;
        checks++; if (gf !== 1'b1 || ft !== 5'd0) $display("FAIL full free got free=%b tag=%0d want tag=0", gf, ft); else passed++;
        checks++; if (bus_if.alloc_ready !== 1'b0) $display("FAIL full ready_in_free got %b want 0", bus_if.alloc_ready); else passed++;
        tick();
        checks++; if (bus_if.alloc_ready !== 1'b1) $display("FAIL full ready_after_free got %b want 1", bus_if.alloc_ready); else passed++;
        checks++; if (bus_if.outstanding !== 6'd31) $display("FAIL full outstanding_after_free got %0d want 31", bus_if.outstanding); else passed++;
        cpl(5'd1);
        drain(gr, n, l, lst, gf, ft);
        checks++; if (gf !== 1'b1 || ft !== 5'd1 || l !== 11'd2) $display("FAIL full second got free=%b tag=%0d len=%0d want tag=1 len=2", gf, ft, l); else passed++;
        // Allocate in the FREE cycle so push and pop share an edge
        alloc(5'd0, 11'd7, 1'b0);
        checks++; if (bus_if.outstanding !== 6'd31) $display("FAIL full push_pop got %0d want 31", bus_if.outstanding); else passed++;
    endtask

    task automatic test_errors();
        logic gr, gf, lst;
        logic [TAG_W-1:0] n, ft;
        logic [LEN_W-1:0] l;
        logic seen_req;
        do_reset();
        cpl(5'd7);
        checks++; if (bus_if.err_unexp_cpl !== 1'b1) $display("FAIL err unalloc got %b want 1", bus_if.err_unexp_cpl); else passed++;
        // Bitmap must not have recorded tag 7 as done
        alloc(5'd7, 11'd4, 1'b0);
        seen_req = 1'b0;
        for (int i = 0; i < 5; i++) begin seen_req |= bus_if.tag_rx_req; tick(); end
        checks++; if (seen_req !== 1'b0) $display("FAIL err bitmap_unchanged got req=%b want 0", seen_req); else passed++;
        do_reset();
        checks++; if (bus_if.err_unexp_cpl !== 1'b0) $display("FAIL err cleared_by_reset got %b want 0", bus_if.err_unexp_cpl); else passed++;
        alloc(5'd9, 11'd16, 1'b1);
        cpl(5'd9);
        checks++; if (bus_if.err_unexp_cpl !== 1'b0) $display("FAIL err legal_cpl got %b want 0", bus_if.err_unexp_cpl); else passed++;
        cpl(5'd9);
        checks++; if (bus_if.err_unexp_cpl !== 1'b1) $display("FAIL err duplicate got %b want 1", bus_if.err_unexp_cpl); else passed++;
        drain(gr, n, l, lst, gf, ft);
        checks++; if (gr !== 1'b1 || n !== 5'd9 || gf !== 1'b1 || ft !== 5'd9) $display("FAIL err drain got req=%b num=%0d free=%b tag=%0d want 9", gr, n, gf, ft); else passed++;
        tick();
        checks++; if (bus_if.err_unexp_cpl !== 1'b1) $display("FAIL err sticky got %b want 1", bus_if.err_unexp_cpl); else passed++;
    endtask

    task automatic test_timeout();
        logic gr, gf, lst;
        logic [TAG_W-1:0] n, ft;
        logic [LEN_W-1:0] l;
        int pulses;
        int at;
        do_reset();
        alloc(5'd5, 11'd8, 1'b0);
        pulses = 0;
        at = -1;
        for (int k = 1; k <= 130; k++) begin
            tick();
            if (bus_if.cpl_timeout) begin
                pulses++;
                at = k;
            end
        end
        checks++; if (pulses !== 1) $display("FAIL timeout pulse_count got %0d want 1", pulses); else passed++;
        checks++; if (at !== 100) $display("FAIL timeout pulse_cycle got %0d want 100", at); else passed++;
        checks++; if (bus_if.tag_rx_req !== 1'b0) $display("FAIL timeout no_req got %b want 0", bus_if.tag_rx_req); else passed++;
        cpl(5'd5);
        drain(gr, n, l, lst, gf, ft);
        checks++; if (gr !== 1'b1 || n !== 5'd5 || l !== 11'd8) $display("FAIL timeout late_req got req=%b num=%0d len=%0d want num=5 len=8", gr, n, l); else passed++;
        checks++; if (gf !== 1'b1 || ft !== 5'd5) $display("FAIL timeout late_free got free=%b tag=%0d want tag=5", gf, ft); else passed++;
        checks++; if (bus_if.err_unexp_cpl !== 1'b0) $display("FAIL timeout err got %b want 0", bus_if.err_unexp_cpl); else passed++;
    endtask

    task automatic test_async_reset();
        int fc;
        int waited;
        do_reset();
        alloc(5'd10, 11'd4, 1'b0);
        alloc(5'd11, 11'd4, 1'b0);
        alloc(5'd12, 11'd4, 1'b0);
        alloc(5'd13, 11'd4, 1'b1);
        cpl(5'd10);
        waited = 0;
        while (!bus_if.tag_rx_req && waited < 10) begin tick(); waited++; end
        checks++; if (bus_if.tag_rx_req !== 1'b1 || bus_if.tag_rx_number !== 5'd10) $display("FAIL async req got req=%b num=%0d want num=10", bus_if.tag_rx_req, bus_if.tag_rx_number); else passed++;
        bus_if.tag_rx_ack = 1'b1;
        tick();
        bus_if.tag_rx_ack = 1'b0;
        checks++; if (bus_if.outstanding !== 6'd4 || bus_if.tag_rx_req !== 1'b0) $display("FAIL async wait_done got outstanding=%0d req=%b want 4/0", bus_if.outstanding, bus_if.tag_rx_req); else passed++;
        fc = free_cnt;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus_if.tag_rx_req !== 1'b0) $display("FAIL async req_cleared got %b want 0", bus_if.tag_rx_req); else passed++;
        checks++; if (bus_if.outstanding !== 6'd0) $display("FAIL async outstanding got %0d want 0", bus_if.outstanding); else passed++;
        checks++; if (bus_if.alloc_ready !== 1'b1) $display("FAIL async alloc_ready got %b want 1", bus_if.alloc_ready); else passed++;
        bus_if.tag_rx_done = 1'b1;
        tick();
        bus_if.tag_rx_done = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (free_cnt !== fc) $display("FAIL async free_pulses got %0d want %0d", free_cnt, fc); else passed++;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_single();
        test_reversed();
        test_full();
        test_errors();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dma_rx_tag_order.md
Name: dma_rx_tag_order

Overview:
- Sits directly upstream of the DMA RX data process stage.
- Records each read-request tag in issue order, together with its DW length and a last-of-DMA flag.
- Collects per-tag "completion fully written to reorder RAM" events and presents tags to the data process stage strictly in issue order, over the tag_rx_req/ack/done handshake.
- Returns each tag to the tag allocator after its data has been drained.

Parameters:
- NUM_TAGS, 32, number of tags; tag i owns RAM rows i*32 .. i*32+31.
- TAG_W, 5, tag number width; log2(NUM_TAGS).
- LEN_W, 11, tag length width in DW (max 512 DW = 128 rows of 16B ... capped by requester at 128 DW per tag).
- TIMEOUT_CYC, 65535, cycles the head tag may wait for completion before a timeout pulse.

Ports:
- clk  in  1  system clock, 125 MHz
- rst  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  requester issued a read TLP with this tag
- alloc_ready  out  1  order queue can accept (not full)
- alloc_tag  in  TAG_W  tag number issued
- alloc_len  in  LEN_W  requested length in DW, 1..128
- alloc_last  in  1  tag is the final tag of the current DMA transfer
- cpl_done_valid  in  1  completion writer: all data for cpl_done_tag is in RAM
- cpl_done_tag  in  TAG_W  tag whose completion finished
- tag_rx_req  out  1  head tag ready for draining
- tag_rx_ack  in  1  one-cycle accept from data process
- tag_rx_last  out  1  head tag's last flag
- tag_rx_number  out  TAG_W  head tag number
- tag_rx_length  out  LEN_W  head tag length, DW
- tag_rx_done  in  1  one-cycle pulse: head tag fully read out
- tag_free_valid  out  1  one-cycle pulse returning a tag to the allocator
- tag_free_tag  out  TAG_W  tag being returned
- outstanding  out  TAG_W+1  entries currently in the order queue
- err_unexp_cpl  out  1  sticky: cpl_done for a tag not outstanding, or a duplicate
- cpl_timeout  out  1  one-cycle pulse when the head wait exceeds TIMEOUT_CYC

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0 except alloc_ready=1.
  - Queue empty, completion bitmap cleared, state IDLE, timeout counter 0.
  - Reset mid-operation discards all queue entries and bitmap bits without any tag_free pulses; the allocator is reset from the same rst.
- Order queue: FIFO of {tag, len, last}, depth NUM_TAGS.
  - Push on alloc_valid&alloc_ready.
  - alloc_ready = !full, registered-free (combinational from count).
  - Push when full is ignored; the requester must honour alloc_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
- Outstanding bitmap pend[NUM_TAGS]:
  - Set on push.
  - Cleared on free.
- Completion bitmap done[NUM_TAGS]:
  - Set on cpl_done_valid if pend[tag]=1 and done[tag]=0.
  - Otherwise err_unexp_cpl<=1 (sticky until rst) and the bitmap is unchanged.
  - Set and free of the same tag in one cycle: the free wins, error is flagged.
- State machine:
  - IDLE: if the queue is non-empty and done[head.tag]=1 -> REQ. Register tag_rx_req=1 and number/length/last from the head; this is 1 cycle after the condition.
  - REQ: outputs held stable. On tag_rx_ack -> WAIT_DONE; tag_rx_req deasserts the next cycle. The data process samples the info in its ack cycle, so the fields stay stable through WAIT_DONE.
  - WAIT_DONE: on tag_rx_done -> FREE.
  - FREE (1 cycle):
    - tag_free_valid=1, tag_free_tag=head.tag.
    - Clear pend/done for that tag and pop the queue -> IDLE.
    - Next head may request no earlier than 2 cycles later.
- Out-of-order completions:
  - Later tags may complete first; they wait in the bitmap.
  - Request order is always allocation order.
- Timeout:
  - Counter runs in IDLE while the queue is non-empty and done[head]=0.
  - Resets on head change or when done[head] sets.
  - At TIMEOUT_CYC: pulse cpl_timeout once per head; saturate, no state change.
- tag_rx_ack outside REQ and tag_rx_done outside WAIT_DONE are ignored.
- outstanding = queue count, registered.

Decomposition:
- Package dma_rx_pkg:
  - TAG_W, LEN_W, NUM_TAGS constants.
  - Order-entry struct {tag, len, last}.
  - State enum IDLE/REQ/WAIT_DONE/FREE.
- Sub-module dma_tag_fifo: synchronous FIFO, distributed RAM, width TAG_W+LEN_W+1, depth NUM_TAGS.
  - Ports: push/pop/full/empty/count, show-ahead head.

Test Plan:
- Single tag, in order: alloc tag 3, len 64, last=1; cpl_done tag 3.
  - -> tag_rx_req 1 cycle later with number=3, length=64, last=1.
  - Ack then done -> tag_free_valid with tag 3; outstanding returns to 0.
- Reversed completions: alloc tags 0,1,2 (len 32); cpl_done order 2,1,0.
  - -> no req until tag 0 completes; requests issue 0,1,2; frees 0,1,2.
- Queue full: 32 allocs -> alloc_ready=0, outstanding=32.
  - Complete and drain tag 0 -> alloc_ready=1 the cycle after FREE.
  - A simultaneous alloc+free leaves outstanding at 31.
- Errors: cpl_done for tag 7 never allocated -> err_unexp_cpl=1, bitmap unchanged. A duplicate cpl_done for an outstanding tag -> same.
- Timeout: TIMEOUT_CYC=100, alloc tag 5 with no completion.
  - -> single cpl_timeout pulse at cycle 100 after the head became valid.
  - A late completion then proceeds normally.
- Async reset: assert rst while in WAIT_DONE with 4 outstanding.
  - -> tag_rx_req=0, outstanding=0, alloc_ready=1 immediately, no tag_free pulses.
